// File: rtl/fft_frame_loader_if.sv
// Complex sample stream into the FFT frame loader.
// One signed re/im pair per valid/ready beat.
interface fft_frame_loader_if #(
    parameter int W = 16
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_re;
    logic [W-1:0] s_im;

    modport master (
        output s_valid,
        output s_re,
        output s_im,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_re,
        input  s_im,
        output s_ready
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Shadow-buffered frame loader for the 16-point CORDIC FFT.
// Holds each frame stable in flight and flags when its results are valid.
module fft_frame_loader #(
    parameter int N           = 16,
    parameter int W           = 16,
    parameter int FFT_LATENCY = 64
) (
    input  logic              clock,
    input  logic              rst_n,
    fft_frame_loader_if.slave s,
    input  logic              abort,
    output logic [N*W-1:0]    xin_bus,
    output logic [N*W-1:0]    yin_bus,
    output logic              busy,
    output logic              result_valid,
    output logic [7:0]        frame_id
);
    localparam int IW = $clog2(N);
    localparam int LW = $clog2(FFT_LATENCY + 1);
    localparam logic [IW-1:0] LAST    = IW'(N - 1);
    localparam logic [LW-1:0] LAT_MAX = LW'(FFT_LATENCY);

    logic [IW-1:0] fill_idx;
    logic          shadow_full;
    logic [LW-1:0] lat_cnt;
    logic [W-1:0]  sh_re [N];
    logic [W-1:0]  sh_im [N];
    logic          accept;
    logic          transfer;

    assign s.s_ready    = rst_n && !shadow_full;
    assign result_valid = busy && (lat_cnt == LAT_MAX);
    assign accept       = s.s_valid && s.s_ready && !abort;
    // A frame may launch into the slot freed by the finishing one
    assign transfer     = shadow_full && (!busy || result_valid) && !abort;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            fill_idx    <= '0;
            shadow_full <= 1'b0;
            for (int i = 0; i < N; i++) begin
                sh_re[i] <= '0;
                sh_im[i] <= '0;
            end
        end else if (abort) begin
            fill_idx    <= '0;
            shadow_full <= 1'b0;
        end else if (accept) begin
            sh_re[fill_idx] <= s.s_re;
            sh_im[fill_idx] <= s.s_im;
            if (fill_idx == LAST) begin
                fill_idx    <= '0;
                shadow_full <= 1'b1;
            end else begin
                fill_idx <= fill_idx + 1'b1;
            end
        end else if (transfer) begin
            shadow_full <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            xin_bus  <= '0;
            yin_bus  <= '0;
            busy     <= 1'b0;
            lat_cnt  <= '0;
            frame_id <= '0;
        end else if (transfer) begin
            // Slot 0 lands in the MSBs as the first FFT input
            for (int i = 0; i < N; i++) begin
                xin_bus[(N-1-i)*W +: W] <= sh_re[i];
                yin_bus[(N-1-i)*W +: W] <= sh_im[i];
            end
            busy     <= 1'b1;
            lat_cnt  <= '0;
            frame_id <= frame_id + 8'd1;
        end else begin
            if (result_valid) begin
                busy <= 1'b0;
            end
            if (busy && lat_cnt != LAT_MAX) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: reset, single/back-to-back
// frames, abort, frame_id wrap and reset during flight.
module tb_fft_frame_loader;
    localparam int N = 16;
    localparam int W = 16;

    logic           clock = 1'b0;
    logic           rst_n;
    logic           abort;
    logic           abort2;
    logic [N*W-1:0] xin_bus;
    logic [N*W-1:0] yin_bus;
    logic [N*W-1:0] xin2;
    logic [N*W-1:0] yin2;
    logic           busy;
    logic           busy2;
    logic           result_valid;
    logic           rv2;
    logic [7:0]     frame_id;
    logic [7:0]     fid2;
    logic [7:0]     prev;
    logic           go;

    int compared   = 0;
    int mismatched = 0;
    int t;
    int acc;
    int t2;
    int t3;
    int trv;
    int drop;
    int early;
    int pulses;
    int wrapped;
    int seq_err;
    int guard;

    fft_frame_loader_if #(.W(W)) sif ();
    fft_frame_loader_if #(.W(W)) sif2 ();

    fft_frame_loader #(
        .N(N), .W(W), .FFT_LATENCY(64)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .s            (sif),
        .abort        (abort),
        .xin_bus      (xin_bus),
        .yin_bus      (yin_bus),
        .busy         (busy),
        .result_valid (result_valid),
        .frame_id     (frame_id)
    );

    fft_frame_loader #(
        .N(N), .W(W), .FFT_LATENCY(4)
    ) dut2 (
        .clock        (clock),
        .rst_n        (rst_n),
        .s            (sif2),
        .abort        (abort2),
        .xin_bus      (xin2),
        .yin_bus      (yin2),
        .busy         (busy2),
        .result_valid (rv2),
        .frame_id     (fid2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        t++;
    endtask

    function automatic logic [W-1:0] slot(input logic [N*W-1:0] b,
                                          input int k);
        return b[(N-1-k)*W +: W];
    endfunction

    initial begin
        t      = 0;
        rst_n  = 1'b1;
        abort  = 1'b0;
        abort2 = 1'b0;
        sif.s_valid  = 1'b1;
        sif.s_re     = 16'h1234;
        sif.s_im     = 16'h0;
        sif2.s_valid = 1'b0;
        sif2.s_re    = 16'h0;
        sif2.s_im    = 16'h0;

        // reset asserted mid-cycle with s_valid high
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", sif.s_ready, 0);
        check("rst_xin0", xin_bus == '0, 1);
        check("rst_busy", busy, 0);
        check("rst_rv", result_valid, 0);
        check("rst_fid", frame_id, 0);
        step();
        step();
        sif.s_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("rel_ready", sif.s_ready, 1);

        // single frame: re=k, im=-k
        for (int k = 0; k < 16; k++) begin
            sif.s_valid = 1'b1;
            sif.s_re = 16'(k);
            sif.s_im = 16'(-k);
            step();
        end
        sif.s_valid = 1'b0;
        check("full_ready", sif.s_ready, 0);
        check("pre_busy", busy, 0);
        step();
        check("x_slot0", slot(xin_bus, 0), 0);
        check("x_slot15", xin_bus[15:0], 15);
        check("y_slot15", yin_bus[15:0], 16'hfff1);
        check("fid1", frame_id, 1);
        check("busy1", busy, 1);
        check("ready_after_xfer", sif.s_ready, 1);
        early = 0;
        repeat (63) begin
            step();
            if (result_valid) early++;
        end
        check("rv_early", early, 0);
        step();
        check("rv_at_65", result_valid, 1);
        check("busy_at_rv", busy, 1);
        step();
        check("rv_pulse_end", result_valid, 0);
        check("busy_clear", busy, 0);

        // back-to-back: 48 samples with continuous s_valid
        t = 0; acc = 0; t2 = 0; t3 = 0; trv = 0; drop = 0;
        while (acc < 48 && t < 300) begin
            sif.s_valid = 1'b1;
            sif.s_re = 16'(200 + acc);
            sif.s_im = 16'(acc);
            go = sif.s_ready;
            step();
            if (go) acc++;
            if (frame_id == 8'd2 && t2 == 0) t2 = t;
            if (frame_id == 8'd3 && t3 == 0) t3 = t;
            if (result_valid && trv == 0) trv = t;
            if (t > 17 && !busy) drop++;
        end
        sif.s_valid = 1'b0;
        check("b2b_acc", acc, 48);
        check("b2b_t_end", t, 98);
        check("b2b_fid2_t", t2, 17);
        check("b2b_rv_t", trv, 81);
        check("b2b_fid3_t", t3, 82);
        check("b2b_busy_drop", drop, 0);
        check("b2b_slot0", slot(xin_bus, 0), 216);
        check("b2b_ready_low", sif.s_ready, 0);
        while (t < 146) step();
        check("f3_rv", result_valid, 1);
        step();
        check("fid4", frame_id, 4);
        check("f4_slot0", slot(xin_bus, 0), 232);
        check("f4_busy", busy, 1);

        // abort while frame 4 is in flight
        for (int k = 0; k < 5; k++) begin
            sif.s_valid = 1'b1;
            sif.s_re = 16'(50 + k);
            step();
        end
        abort = 1'b1;
        sif.s_re = 16'd77;
        step();
        abort = 1'b0;
        for (int k = 0; k < 16; k++) begin
            sif.s_valid = 1'b1;
            sif.s_re = 16'(100 + k);
            sif.s_im = 16'(k);
            step();
        end
        sif.s_valid = 1'b0;
        check("ab_full", sif.s_ready, 0);
        check("ab_hold", slot(xin_bus, 0), 232);
        early = 0;
        while (t < 210) begin
            step();
            if (result_valid) early++;
        end
        check("ab_rv_early", early, 0);
        step();
        check("ab_rv_t", result_valid, 1);
        check("ab_hold_rv", slot(xin_bus, 0), 232);
        step();
        check("ab_fid5", frame_id, 5);
        check("ab_slot0", slot(xin_bus, 0), 100);
        check("ab_slot15", xin_bus[15:0], 115);
        check("ab_yslot15", yin_bus[15:0], 15);
        while (busy && t < 400) step();
        check("drain", busy, 0);

        // frame_id wrap on the short-latency instance
        acc = 0; pulses = 0; wrapped = 0; seq_err = 0; guard = 0;
        prev = fid2;
        while (acc < 257 * 16 && guard < 6000) begin
            sif2.s_valid = 1'b1;
            sif2.s_re = 16'(acc);
            go = sif2.s_ready;
            step();
            guard++;
            if (go) acc++;
            if (rv2) pulses++;
            if (fid2 != prev) begin
                if (fid2 != prev + 8'd1) seq_err++;
                if (fid2 == 8'd0 && prev == 8'd255) wrapped++;
                prev = fid2;
            end
        end
        sif2.s_valid = 1'b0;
        repeat (30) begin
            step();
            if (rv2) pulses++;
            if (fid2 != prev) begin
                if (fid2 != prev + 8'd1) seq_err++;
                prev = fid2;
            end
        end
        check("wrap_acc", acc, 257 * 16);
        check("wrap_pulses", pulses, 257);
        check("wrap_255_0", wrapped, 1);
        check("wrap_seq", seq_err, 0);
        check("wrap_fid", fid2, 1);

        // reset during flight
        for (int k = 0; k < 16; k++) begin
            sif.s_valid = 1'b1;
            sif.s_re = 16'(300 + k);
            step();
        end
        sif.s_valid = 1'b0;
        step();
        check("mf_fid6", frame_id, 6);
        repeat (10) step();
        sif.s_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("mf_ready", sif.s_ready, 0);
        check("mf_xin0", xin_bus == '0, 1);
        check("mf_busy", busy, 0);
        check("mf_rv", result_valid, 0);
        check("mf_fid", frame_id, 0);
        step();
        step();
        sif.s_valid = 1'b0;
        rst_n = 1'b1;
        early = 0;
        repeat (80) begin
            step();
            if (result_valid) early++;
        end
        check("mf_no_rv", early, 0);
        check("mf_hold0", xin_bus == '0, 1);
        for (int k = 0; k < 16; k++) begin
            sif.s_valid = 1'b1;
            sif.s_re = 16'(400 + k);
            step();
        end
        sif.s_valid = 1'b0;
        step();
        check("mf_fid1", frame_id, 1);
        check("mf_slot0", slot(xin_bus, 0), 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
